// File: rtl/uop_pkg.sv
// Shared micro-op definitions and rename-queue sizing constants.
package uop_pkg;

    // Decoded micro-op as handed from decode to rename.
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } uop_insn;

    localparam int UOPQ_DEPTH = 16;
    localparam int UOPQ_WIDTH = 2;

    localparam uop_insn UOP_ZERO = '0;

    // Number of uops carried by a decode slot-valid pattern. The illegal
    // pattern 10 carries nothing: slot 0 is empty and slot 1 is ignored.
    function automatic logic [1:0] legal_slot_count(input logic [1:0] valid);
        logic [1:0] n;
        case (valid)
            2'b01:   n = 2'd1;
            2'b11:   n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uop_rename_queue_chk.sv
// Protocol and invariant checks for uop_rename_queue, observed at its ports.
module uop_rename_queue_chk #(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic             clk_in,
    input logic             rst_N_in,
    input logic [1:0]       enq_valid_in,
    input logic [1:0]       q_slot_valid_out,
    input logic [PTR_W:0]   count_out
);

    // Occupancy (tail - head of the wrap-bit pointers) never exceeds the ring size.
    a_count_bound: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        count_out <= (PTR_W+1)'(DEPTH));

    // The presented pair is always packed towards slot 0.
    a_slot_packed: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        q_slot_valid_out != 2'b10);

    // Decode must never offer slot 1 without slot 0.
    a_enq_legal: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        enq_valid_in != 2'b10);

    // Any occupancy means at least slot 0 is presented, and vice versa.
    a_valid_matches_count: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        (q_slot_valid_out == 2'b00) == (count_out == (PTR_W+1)'(0)));

endmodule

// File: rtl/uop_rename_queue.sv
// Two-wide circular FIFO between decode and rename. Decode pushes up to two
// uops per cycle; the RAT takes the oldest one or two presented uops as a
// unit. Pointers carry an extra wrap bit so occupancy is simply tail - head.
module uop_rename_queue
    import uop_pkg::*;
#(
    parameter  int DEPTH = UOPQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk_in,
    input  logic                      rst_N_in,
    input  logic                      flush_in,
    input  logic [1:0]                enq_valid_in,
    input  uop_insn [UOPQ_WIDTH-1:0]  enq_uop_in,
    output logic                      enq_ready_out,
    output logic                      q_valid_out,
    output logic [1:0]                q_slot_valid_out,
    output uop_insn [UOPQ_WIDTH-1:0]  q_uop_out,
    input  logic                      q_increment_ready_in,
    output logic [PTR_W:0]            count_out
);

    typedef logic [PTR_W:0]   ptr_t;
    typedef logic [PTR_W-1:0] idx_t;

    localparam ptr_t PTR_ZERO  = ptr_t'(0);
    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam ptr_t PTR_TWO   = ptr_t'(2);
    // A full pair fits only while at least two entries are free.
    localparam ptr_t ENQ_LIMIT = ptr_t'(DEPTH - 2);
    localparam idx_t IDX_ONE   = idx_t'(1);

    ptr_t    head_q, head_d;
    ptr_t    tail_q, tail_d;
    uop_insn mem_q [DEPTH];

    ptr_t    count_s;
    ptr_t    enq_n_s;
    ptr_t    deq_n_s;
    logic    enq_fire_s;
    logic    deq_fire_s;
    idx_t    rd_idx0_s, rd_idx1_s;
    idx_t    wr_idx0_s, wr_idx1_s;

    // Presentation to the RAT, derived purely from registered state (no enq bypass).
    always_comb begin
        count_s          = tail_q - head_q;
        rd_idx0_s        = head_q[PTR_W-1:0];
        rd_idx1_s        = rd_idx0_s + IDX_ONE;   // wraps naturally mod DEPTH
        q_valid_out      = (count_s != PTR_ZERO);
        if (count_s == PTR_ZERO) begin
            q_slot_valid_out = 2'b00;
        end else if (count_s == PTR_ONE) begin
            q_slot_valid_out = 2'b01;
        end else begin
            q_slot_valid_out = 2'b11;
        end
        q_uop_out[0]     = q_slot_valid_out[0] ? mem_q[rd_idx0_s] : UOP_ZERO;
        q_uop_out[1]     = q_slot_valid_out[1] ? mem_q[rd_idx1_s] : UOP_ZERO;
        // Readiness looks at current occupancy only; a same-cycle dequeue is not credited.
        enq_ready_out    = (count_s <= ENQ_LIMIT);
        count_out        = count_s;
    end

    // Handshake decode and next pointer values; flush overrides both handshakes.
    always_comb begin
        wr_idx0_s  = tail_q[PTR_W-1:0];
        wr_idx1_s  = wr_idx0_s + IDX_ONE;
        enq_n_s    = ptr_t'(legal_slot_count(enq_valid_in));
        enq_fire_s = enq_ready_out && (enq_n_s != PTR_ZERO) && !flush_in;
        deq_n_s    = (q_slot_valid_out == 2'b11) ? PTR_TWO : PTR_ONE;
        deq_fire_s = q_valid_out && q_increment_ready_in && !flush_in;
        head_d     = head_q;
        tail_d     = tail_q;
        if (flush_in) begin
            head_d = PTR_ZERO;
            tail_d = PTR_ZERO;
        end else begin
            if (enq_fire_s) begin
                tail_d = tail_q + enq_n_s;
            end else begin
                tail_d = tail_q;
            end
            if (deq_fire_s) begin
                head_d = head_q + deq_n_s;
            end else begin
                head_d = head_q;
            end
        end
    end

    // Head/tail pointer registers.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head_q <= PTR_ZERO;
            tail_q <= PTR_ZERO;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Ring storage writes; contents are left unreset since occupancy gates every read.
    always_ff @(posedge clk_in) begin
        if (enq_fire_s) begin
            mem_q[wr_idx0_s] <= enq_uop_in[0];
            if (enq_n_s == PTR_TWO) begin
                mem_q[wr_idx1_s] <= enq_uop_in[1];
            end
        end
    end

endmodule

// File: tb/tb_uop_rename_queue.sv
// Self-checking bench for uop_rename_queue against a queue-based reference model.
module tb_uop_rename_queue;
    import uop_pkg::*;

    localparam int DEPTH = 16;

    logic           clk_in;
    logic           rst_N_in;
    logic           flush_in;
    logic [1:0]     enq_valid_in;
    uop_insn [1:0]  enq_uop_in;
    logic           enq_ready_out;
    logic           q_valid_out;
    logic [1:0]     q_slot_valid_out;
    uop_insn [1:0]  q_uop_out;
    logic           q_increment_ready_in;
    logic [4:0]     count_out;

    int checks;
    int fails;

    uop_insn model_q[$];

    uop_rename_queue #(.DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .flush_in(flush_in),
        .enq_valid_in(enq_valid_in), .enq_uop_in(enq_uop_in),
        .enq_ready_out(enq_ready_out), .q_valid_out(q_valid_out),
        .q_slot_valid_out(q_slot_valid_out), .q_uop_out(q_uop_out),
        .q_increment_ready_in(q_increment_ready_in), .count_out(count_out)
    );

    uop_rename_queue_chk #(.DEPTH(DEPTH)) chk (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .enq_valid_in(enq_valid_in),
        .q_slot_valid_out(q_slot_valid_out), .count_out(count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic uop_insn rand_uop();
        uop_insn u;
        u.pc     = $urandom;
        u.opcode = 7'($urandom);
        u.rd     = 5'($urandom);
        u.rs1    = 5'($urandom);
        u.rs2    = 5'($urandom);
        u.imm    = $urandom;
        return u;
    endfunction

    function automatic int exp_count();
        return model_q.size();
    endfunction

    function automatic logic [1:0] exp_slots();
        if (model_q.size() == 0) return 2'b00;
        if (model_q.size() == 1) return 2'b01;
        return 2'b11;
    endfunction

    function automatic uop_insn exp_uop(input int slot);
        if (model_q.size() > slot) return model_q[slot];
        return UOP_ZERO;
    endfunction

    // One clock cycle of stimulus; the model is advanced from the pre-edge occupancy.
    task automatic step(input logic [1:0] ev, input uop_insn u0, input uop_insn u1,
                        input logic rdy, input logic fl);
        int sz;
        enq_valid_in         = ev;
        enq_uop_in[0]        = u0;
        enq_uop_in[1]        = u1;
        q_increment_ready_in = rdy;
        flush_in             = fl;
        sz = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (rdy && sz > 0) begin
                for (int i = 0; i < ((sz >= 2) ? 2 : 1); i++) void'(model_q.pop_front());
            end
            if (DEPTH - sz >= 2) begin
                if (ev[0]) model_q.push_back(u0);
                if (ev == 2'b11) model_q.push_back(u1);
            end
        end
        @(posedge clk_in);
        #1;
        enq_valid_in         = 2'b00;
        q_increment_ready_in = 1'b0;
        flush_in             = 1'b0;
    endtask

    task automatic idle_drain();
        for (int i = 0; i < DEPTH && model_q.size() > 0; i++) step(2'b00, UOP_ZERO, UOP_ZERO, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        checks++; if (count_out !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count_out); end
        checks++; if (q_valid_out !== 1'b0 || q_slot_valid_out !== 2'b00) begin fails++; $display("FAIL reset_qvalid: got %b/%b want 0/00", q_valid_out, q_slot_valid_out); end
        checks++; if (q_uop_out !== {UOP_ZERO, UOP_ZERO}) begin fails++; $display("FAIL reset_uop: got %h want 0", q_uop_out); end
        checks++; if (enq_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", enq_ready_out); end
        for (int i = 0; i < 3; i++) step(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0);
        checks++; if (count_out !== 5'd6) begin fails++; $display("FAIL prefill_count: got %0d want 6", count_out); end
        // Asynchronous reset between clock edges.
        #3 rst_N_in = 1'b0;
        #1;
        model_q.delete();
        checks++; if (count_out !== 5'd0 || q_valid_out !== 1'b0) begin fails++; $display("FAIL async_reset_state: got count=%0d qv=%b want 0/0", count_out, q_valid_out); end
        checks++; if (q_uop_out !== {UOP_ZERO, UOP_ZERO} || q_slot_valid_out !== 2'b00) begin fails++; $display("FAIL async_reset_uop: got %h/%b want 0/00", q_uop_out, q_slot_valid_out); end
        checks++; if (enq_ready_out !== 1'b1) begin fails++; $display("FAIL async_reset_ready: got %b want 1", enq_ready_out); end
        #2 rst_N_in = 1'b1;
        @(posedge clk_in); #1;
        checks++; if (count_out !== 5'd0) begin fails++; $display("FAIL post_reset_count: got %0d want 0", count_out); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 7; i++) step(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0);
        checks++; if (count_out !== 5'd14 || enq_ready_out !== 1'b1) begin fails++; $display("FAIL fill14: got count=%0d rdy=%b want 14/1", count_out, enq_ready_out); end
        step(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0);
        checks++; if (count_out !== 5'd16 || enq_ready_out !== 1'b0) begin fails++; $display("FAIL fill16: got count=%0d rdy=%b want 16/0", count_out, enq_ready_out); end
        step(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0);
        checks++; if (count_out !== 5'd16) begin fails++; $display("FAIL full_drop: got count=%0d want 16", count_out); end
        for (int i = 0; i < 8 && model_q.size() > 0; i++) begin
            checks++; if (q_uop_out[0] !== exp_uop(0) || q_uop_out[1] !== exp_uop(1)) begin fails++; $display("FAIL fill_drain_order: got %h want %h_%h", q_uop_out, exp_uop(1), exp_uop(0)); end
            step(2'b00, UOP_ZERO, UOP_ZERO, 1'b1, 1'b0);
        end
        checks++; if (count_out !== 5'd0) begin fails++; $display("FAIL fill_drained: got count=%0d want 0", count_out); end
    endtask

    task automatic test_odd();
        uop_insn a, b, c;
        a = rand_uop(); b = rand_uop(); c = rand_uop();
        step(2'b01, a, UOP_ZERO, 1'b0, 1'b0);
        step(2'b11, b, c, 1'b0, 1'b0);
        checks++; if (q_slot_valid_out !== 2'b11 || q_uop_out[0] !== a || q_uop_out[1] !== b) begin fails++; $display("FAIL odd_pair: got %b %h want 11 A,B", q_slot_valid_out, q_uop_out); end
        step(2'b00, UOP_ZERO, UOP_ZERO, 1'b1, 1'b0);
        checks++; if (q_slot_valid_out !== 2'b01 || q_uop_out[0] !== c || q_uop_out[1] !== UOP_ZERO) begin fails++; $display("FAIL odd_single: got %b %h want 01 C,0", q_slot_valid_out, q_uop_out); end
        step(2'b00, UOP_ZERO, UOP_ZERO, 1'b1, 1'b0);
        checks++; if (q_valid_out !== 1'b0 || count_out !== 5'd0) begin fails++; $display("FAIL odd_empty: got qv=%b count=%0d want 0/0", q_valid_out, count_out); end
    endtask

    // Head is left at an odd index here, so pairs straddle the 15/0 wrap.
    task automatic test_wrap();
        uop_insn seq[$];
        int e;
        e = 0;
        for (int c = 0; c < 17; c++) begin
            uop_insn u0, u1;
            u0 = rand_uop(); u1 = rand_uop();
            if (c > 0) begin
                checks++; if (count_out !== 5'd2) begin fails++; $display("FAIL wrap_count: cycle %0d got %0d want 2", c, count_out); end
                checks++; if (q_uop_out[0] !== seq[e] || q_uop_out[1] !== seq[e+1]) begin fails++; $display("FAIL wrap_order: cycle %0d got %h want %h_%h", c, q_uop_out, seq[e+1], seq[e]); end
                e += 2;
            end
            seq.push_back(u0); seq.push_back(u1);
            step(2'b11, u0, u1, 1'b1, 1'b0);
        end
        checks++; if (q_uop_out[0] !== seq[e] || q_uop_out[1] !== seq[e+1]) begin fails++; $display("FAIL wrap_tail: got %h want %h_%h", q_uop_out, seq[e+1], seq[e]); end
        idle_drain();
    endtask

    task automatic test_flush();
        uop_insn n;
        for (int i = 0; i < 4; i++) step(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0);
        step(2'b01, rand_uop(), UOP_ZERO, 1'b0, 1'b0);
        checks++; if (count_out !== 5'd9) begin fails++; $display("FAIL flush_pre: got count=%0d want 9", count_out); end
        step(2'b11, rand_uop(), rand_uop(), 1'b1, 1'b1);
        checks++; if (count_out !== 5'd0 || q_valid_out !== 1'b0) begin fails++; $display("FAIL flush_post: got count=%0d qv=%b want 0/0", count_out, q_valid_out); end
        for (int i = 0; i < 3; i++) begin
            step(2'b00, UOP_ZERO, UOP_ZERO, 1'b1, 1'b0);
            checks++; if (q_valid_out !== 1'b0) begin fails++; $display("FAIL flush_ghost: got qv=%b want 0", q_valid_out); end
        end
        n = rand_uop();
        step(2'b01, n, UOP_ZERO, 1'b0, 1'b0);
        checks++; if (count_out !== 5'd1 || q_uop_out[0] !== n) begin fails++; $display("FAIL flush_restart: got count=%0d uop=%h want 1/%h", count_out, q_uop_out[0], n); end
        idle_drain();
    endtask

    task automatic test_backpressure();
        uop_insn x;
        for (int i = 0; i < 7; i++) step(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0);
        step(2'b01, rand_uop(), UOP_ZERO, 1'b0, 1'b0);
        checks++; if (count_out !== 5'd15 || enq_ready_out !== 1'b0) begin fails++; $display("FAIL bp_15: got count=%0d rdy=%b want 15/0", count_out, enq_ready_out); end
        x = rand_uop();
        step(2'b01, x, UOP_ZERO, 1'b1, 1'b0);
        checks++; if (count_out !== 5'd13 || enq_ready_out !== 1'b1) begin fails++; $display("FAIL bp_13: got count=%0d rdy=%b want 13/1", count_out, enq_ready_out); end
        checks++; if (q_uop_out[0] !== exp_uop(0) || q_uop_out[1] !== exp_uop(1)) begin fails++; $display("FAIL bp_head: got %h want %h_%h", q_uop_out, exp_uop(1), exp_uop(0)); end
        idle_drain();
    endtask

    task automatic test_random();
        logic [1:0] ev;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(2, 0))
                0:       ev = 2'b00;
                1:       ev = 2'b01;
                default: ev = 2'b11;
            endcase
            step(ev, rand_uop(), rand_uop(), ($urandom_range(9, 0) < 4), ($urandom_range(39, 0) == 0));
            checks++;
            if (count_out !== 5'(exp_count()) || q_valid_out !== (exp_count() > 0) ||
                q_slot_valid_out !== exp_slots() || enq_ready_out !== (DEPTH - exp_count() >= 2) ||
                q_uop_out[0] !== exp_uop(0) || q_uop_out[1] !== exp_uop(1)) begin
                fails++;
                $display("FAIL random: cycle %0d got count=%0d qv=%b sv=%b rdy=%b u=%h want count=%0d sv=%b u=%h_%h",
                         c, count_out, q_valid_out, q_slot_valid_out, enq_ready_out, q_uop_out,
                         exp_count(), exp_slots(), exp_uop(1), exp_uop(0));
            end
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        rst_N_in = 1'b0; flush_in = 1'b0; enq_valid_in = 2'b00;
        enq_uop_in = {UOP_ZERO, UOP_ZERO}; q_increment_ready_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #3 rst_N_in = 1'b1;
        @(posedge clk_in); #1;
        test_reset();
        test_fill();
        test_odd();
        test_wrap();
        test_flush();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uop_rename_queue.md
Name: uop_rename_queue

Overview:
- Circular FIFO between decode and rename.
- Accepts up to 2 decoded uops per cycle from decode and presents up to 2 oldest uops per cycle to the RAT (q_valid / instr / q_increment_ready handshake).
- Decouples decode bandwidth from rename stalls caused by ROB-full or FRL-empty back-pressure.
- Flushed wholesale on branch misprediction.

Parameters:
- DEPTH, 16, number of uop entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), index width (derived; not overridden).

Ports:
- clk_in  input  1  clock
- rst_N_in  input  1  reset, asynchronous, active-low
- flush_in  input  1  discard all entries (misprediction/exception)
- enq_valid_in  input  2  per-slot enqueue valid from decode; legal values 00, 01, 11
- enq_uop_in  input  2 x uop_pkg::uop_insn  uops from decode; slot 0 is older
- enq_ready_out  output  1  queue can accept a full pair this cycle
- q_valid_out  output  1  at least one uop is presented to the RAT
- q_slot_valid_out  output  2  per-slot valid of the presented pair; 01 or 11 when q_valid_out=1
- q_uop_out  output  2 x uop_pkg::uop_insn  presented uops; slot 0 is the oldest entry
- q_increment_ready_in  input  1  RAT consumes all presented valid slots this cycle
- count_out  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry ring with head and tail pointers of PTR_W+1 bits (extra wrap bit).
  - count = tail - head.
  - Indices taken mod DEPTH; a pair may straddle the wrap point (slot 1 reads (head+1) mod DEPTH).
- Reset (async assert, sync release): head=0, tail=0, count_out=0, q_valid_out=0, q_slot_valid_out=00, q_uop_out all-zero, enq_ready_out=1. Storage array is not reset.
- Output presentation is combinational from registered state:
  - q_valid_out = (count >= 1).
  - q_slot_valid_out = 00 if count==0; 01 if count==1; 11 if count>=2.
  - Invalid slots drive q_uop_out as all-zero.
- enq_ready_out = (DEPTH - count) >= 2, using current count only; same-cycle dequeue is not credited.
- Enqueue fires when enq_ready_out=1 and enq_valid_in != 00.
  - Writes slot 0 at tail; writes slot 1 at tail+1 if enq_valid_in=11.
  - tail advances by popcount(enq_valid_in).
  - Enqueue while not ready: dropped, no state change. Decode must hold its data.
  - enq_valid_in=10 is illegal: slot 1 is ignored and a simulation assertion fires.
- Dequeue fires when q_valid_out=1 and q_increment_ready_in=1; head advances by popcount(q_slot_valid_out). No partial consumption.
- Latency: a uop enqueued in cycle N is presentable in cycle N+1 at the earliest. There is no bypass from enq to q outputs.
- Simultaneous enqueue and dequeue: both apply; count_next = count + enq_n - deq_n.
- Flush (highest priority):
  - Next cycle head=tail=0 and count=0.
  - Any enqueue and any dequeue handshake in the flush cycle are ignored.
  - Outputs in the flush cycle still reflect pre-flush state; the RAT must ignore them under its own flush.
- Full (count==DEPTH) and count==DEPTH-1: enq_ready_out=0.
- Empty: q_valid_out=0; q_increment_ready_in is don't-care.
- Assertions:
  - count never exceeds DEPTH.
  - q_slot_valid_out never equals 10.
  - No pointer wrap-bit corruption: tail - head <= DEPTH.

Decomposition:
- uop_pkg: keep the existing uop_insn typedef; add constants UOPQ_DEPTH (16) and UOPQ_WIDTH (2). The top-level backend instantiates with DEPTH=uop_pkg::UOPQ_DEPTH.
- No sub-module. Pointer, count and ring storage are one module; storage is a plain register array (2 write, 2 read), with no SRAM macro.

Test Plan:
1. Reset mid-operation: fill with 6 uops, pulse rst_N_in low asynchronously between clock edges -> count_out=0, q_valid_out=0, q_uop_out=0, enq_ready_out=1 immediately, before the next edge.
2. Pairwise fill with q_increment_ready_in=0, DEPTH=16: 7 pair-enqueues -> count_out=14, enq_ready_out=1. The 8th pair -> count_out=16, enq_ready_out=0. A further enq is dropped; count stays 16.
3. Odd count and single slot: enqueue 01 (uop A) then 11 (B,C), then ready=1 each cycle -> presents {A,B} with slot valid 11, then {C} with slot valid 01 and slot 1 zeroed, then q_valid_out=0. Order A,B,C preserved.
4. Wrap-around: cycle 32 uops through with continuous enq 11 and ready=1 -> every uop exits in order, including the pair straddling index 15/0. count_out is steady at 2 after warm-up.
5. Flush collision: count=9, assert flush_in together with enq 11 and a RAT handshake -> next cycle count_out=0, q_valid_out=0. The flushed-cycle enqueued uops never appear.
6. Backpressure near full: count=15, enq 01 -> dropped (enq_ready_out=0). The same cycle's dequeue of 2 still applies -> count_out=13 next cycle.
